// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Bundle between the decode stage and the hazard controller.
//            The decode side (master) supplies decoded register fields,
//            redirect and freeze requests. The controller (slave) returns
//            the IF/ID enables, the ID/EX bubble, the IF/ID flush, the
//            per-operand forwarding selects, tracked-stage valids and
//            performance counters.
// Ports    : id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
//            id_is_load, redirect, ext_stall                (master -> slave)
//            if_en, id_en, ex_bubble, id_flush, fwd_a, fwd_b,
//            stage_valid, stall_cnt, flush_cnt              (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 3,
  parameter int REG_AW = 5,
  parameter int FW     = $clog2(NSTAGE + 1)
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr;
  logic              id_is_load;
  logic              redirect;
  logic              ext_stall;

  logic              if_en;
  logic              id_en;
  logic              ex_bubble;
  logic              id_flush;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [NSTAGE-1:0] stage_valid;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
           id_is_load, redirect, ext_stall,
    input  if_en, id_en, ex_bubble, id_flush, fwd_a, fwd_b, stage_valid,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
           id_is_load, redirect, ext_stall,
    output if_en, id_en, ex_bubble, id_flush, fwd_a, fwd_b, stage_valid,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard, forwarding and stall/flush controller for an in-order
//            MIPS pipeline with NSTAGE tracked post-decode stages
//            (stage 1 = EX, stage NSTAGE = WB) and a configurable load
//            forwarding latency LOAD_LAT.
// Ports    : clk   - clock, rising edge
//            reset - synchronous, active-high
//            hz    - pipe_hazard_ctrl_if.slave (decode fields in,
//                    pipeline controls / forwarding selects / perf out)
// Config   : PIPE_HAZARD_PERF_EN - when defined, implements the saturating
//            16-bit stall_cnt / flush_cnt counters; otherwise both read 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int NSTAGE   = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int FW       = $clog2(NSTAGE + 1)
) (
  input  wire                 clk,
  input  wire                 reset,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  // Tracked stage entries, index 1 = EX (youngest) .. NSTAGE = WB (oldest).
  logic [NSTAGE:1]   r_valid;
  logic [NSTAGE:1]   r_wr;
  logic [NSTAGE:1]   r_ld;
  logic [REG_AW-1:0] r_rd [1:NSTAGE];

  logic [FW-1:0]     w_win_a;
  logic [FW-1:0]     w_win_b;
  logic              w_lu_a;
  logic              w_lu_b;
  logic              w_load_use;
  logic              w_insert;

  // Scanning from oldest to youngest lets the youngest match overwrite
  // older ones, so the lowest stage index wins.
  always_comb begin
    w_win_a = '0;
    w_win_b = '0;
    w_lu_a  = 1'b0;
    w_lu_b  = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (hz.id_use_rs && (hz.id_rs != '0) && r_valid[k] && r_wr[k] &&
          (r_rd[k] == hz.id_rs)) begin
        w_win_a = FW'(k);
        w_lu_a  = r_ld[k] && (k < LOAD_LAT);
      end
      if (hz.id_use_rt && (hz.id_rt != '0) && r_valid[k] && r_wr[k] &&
          (r_rd[k] == hz.id_rt)) begin
        w_win_b = FW'(k);
        w_lu_b  = r_ld[k] && (k < LOAD_LAT);
      end
    end
  end

  assign w_load_use = hz.id_valid && (w_lu_a || w_lu_b);
  // A redirect kills the instruction in ID, so it takes precedence over
  // a load-use stall; either way stage 1 receives a bubble.
  assign w_insert   = !hz.redirect && !w_load_use;

  always_comb begin
    hz.if_en     = 1'b1;
    hz.id_en     = 1'b1;
    hz.ex_bubble = 1'b0;
    hz.id_flush  = 1'b0;
    hz.fwd_a     = w_win_a;
    hz.fwd_b     = w_win_b;
    if (reset) begin
      hz.fwd_a = '0;
      hz.fwd_b = '0;
    end else if (hz.ext_stall) begin
      hz.if_en = 1'b0;
      hz.id_en = 1'b0;
    end else if (hz.redirect) begin
      hz.id_flush  = 1'b1;
      hz.ex_bubble = 1'b1;
      hz.id_en     = 1'b0;
    end else if (w_load_use) begin
      hz.if_en     = 1'b0;
      hz.id_en     = 1'b0;
      hz.ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_wr    <= '0;
      r_ld    <= '0;
      for (int k = 1; k <= NSTAGE; k++) begin
        r_rd[k] <= '0;
      end
    end else if (!hz.ext_stall) begin
      for (int k = 2; k <= NSTAGE; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_ld[k]    <= r_ld[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      if (w_insert) begin
        r_valid[1] <= hz.id_valid;
        r_wr[1]    <= hz.id_wr & hz.id_valid;
        r_ld[1]    <= hz.id_is_load;
        r_rd[1]    <= hz.id_rd;
      end else begin
        r_valid[1] <= 1'b0;
        r_wr[1]    <= 1'b0;
        r_ld[1]    <= 1'b0;
        r_rd[1]    <= '0;
      end
    end
  end

  assign hz.stage_valid = r_valid;

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hz.ext_stall) begin
      if (hz.redirect) begin
        if (r_flush_cnt != C_CNT_MAX) r_flush_cnt <= r_flush_cnt + 16'd1;
      end else if (w_load_use) begin
        if (r_stall_cnt != C_CNT_MAX) r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = 16'd0;
  assign hz.flush_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl with default
//            parameters: directed scenarios followed by random traffic,
//            compared against a queue-style reference model of the pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
  localparam int NSTAGE   = 3;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 2;
  localparam int FW       = $clog2(NSTAGE + 1);
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .FW(FW)) hz ();

  pipe_hazard_ctrl #(
    .NSTAGE(NSTAGE), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .FW(FW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference pipe: element k describes the instruction k stages past ID.
  typedef struct {
    bit valid;
    bit wr;
    int rd;
    bit ld;
  } entry_t;
  entry_t pipe_m [1:NSTAGE];
  int     m_stall;
  int     m_flush;

  // Expected outputs for the current cycle.
  bit e_if_en, e_id_en, e_bubble, e_flush, e_lu;
  int e_fwd_a, e_fwd_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int youngest(input bit use_s, input int s);
    if (!use_s || s == 0) return 0;
    for (int k = 1; k <= NSTAGE; k++)
      if (pipe_m[k].valid && pipe_m[k].wr && pipe_m[k].rd == s) return k;
    return 0;
  endfunction

  task automatic predict();
    int wa, wb;
    wa = youngest(hz.id_use_rs, int'(hz.id_rs));
    wb = youngest(hz.id_use_rt, int'(hz.id_rt));
    e_lu = hz.id_valid &&
           ((wa != 0 && pipe_m[wa].ld && wa < LOAD_LAT) ||
            (wb != 0 && pipe_m[wb].ld && wb < LOAD_LAT));
    e_fwd_a = wa; e_fwd_b = wb;
    e_if_en = 1; e_id_en = 1; e_bubble = 0; e_flush = 0;
    if (reset) begin
      e_fwd_a = 0; e_fwd_b = 0;
    end else if (hz.ext_stall) begin
      e_if_en = 0; e_id_en = 0;
    end else if (hz.redirect) begin
      e_flush = 1; e_bubble = 1; e_id_en = 0;
    end else if (e_lu) begin
      e_if_en = 0; e_id_en = 0; e_bubble = 1;
    end
  endtask

  function automatic logic [NSTAGE-1:0] model_valid();
    logic [NSTAGE-1:0] v;
    for (int k = 1; k <= NSTAGE; k++) v[k-1] = pipe_m[k].valid;
    return v;
  endfunction

  // Predict from pre-edge inputs, then check every output at the negedge.
  task automatic sample();
    predict();
    @(negedge clk);
    chk("if_en",       32'(hz.if_en),       32'(e_if_en));
    chk("id_en",       32'(hz.id_en),       32'(e_id_en));
    chk("ex_bubble",   32'(hz.ex_bubble),   32'(e_bubble));
    chk("id_flush",    32'(hz.id_flush),    32'(e_flush));
    chk("fwd_a",       32'(hz.fwd_a),       32'(e_fwd_a));
    chk("fwd_b",       32'(hz.fwd_b),       32'(e_fwd_b));
    chk("stage_valid", 32'(hz.stage_valid), 32'(model_valid()));
    chk("stall_cnt",   32'(hz.stall_cnt),   PERF ? 32'(m_stall) : 32'd0);
    chk("flush_cnt",   32'(hz.flush_cnt),   PERF ? 32'(m_flush) : 32'd0);
  endtask

  // Advance the model with the same inputs used by sample().
  task automatic tick();
    entry_t nw;
    @(posedge clk);
    if (reset) begin
      for (int k = 1; k <= NSTAGE; k++) pipe_m[k] = '{0, 0, 0, 0};
      m_stall = 0; m_flush = 0;
    end else if (!hz.ext_stall) begin
      if (hz.redirect || e_lu) nw = '{0, 0, 0, 0};
      else nw = '{hz.id_valid, hz.id_wr & hz.id_valid, int'(hz.id_rd), hz.id_is_load};
      for (int k = NSTAGE; k >= 2; k--) pipe_m[k] = pipe_m[k-1];
      pipe_m[1] = nw;
      if (hz.redirect) m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
      else if (e_lu)   m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt,
                        input bit urt, input int rd, input bit wr, input bit ld);
    hz.id_valid = v;   hz.id_rs = REG_AW'(rs); hz.id_use_rs = urs;
    hz.id_rt = REG_AW'(rt); hz.id_use_rt = urt;
    hz.id_rd = REG_AW'(rd); hz.id_wr = wr;     hz.id_is_load = ld;
  endtask

  initial begin
    for (int k = 1; k <= NSTAGE; k++) pipe_m[k] = '{0, 0, 0, 0};
    m_stall = 0; m_flush = 0;
    reset = 1'b1;
    hz.redirect = 1'b0; hz.ext_stall = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    sample(); tick();
    sample(); tick();
    reset = 1'b0;

    // ALU forwarding: add r3, then read r3 from stage 1, then stage 2.
    set_id(1, 0, 0, 0, 0, 3, 1, 0); sample(); tick();
    set_id(1, 3, 1, 0, 0, 4, 1, 0); sample();
    chk("alu_fwd1", 32'(hz.fwd_a), 32'd1); chk("alu_noburst", 32'(hz.ex_bubble), 32'd0);
    tick();
    set_id(1, 3, 1, 0, 0, 0, 0, 0); sample();
    chk("alu_fwd1_r4_not_r3", 32'(hz.fwd_a), 32'd2);
    tick();

    // Load-use: lw r5, then consumer of r5 stalls one cycle.
    set_id(1, 0, 0, 0, 0, 5, 1, 1); sample(); tick();
    set_id(1, 0, 0, 5, 1, 6, 1, 0); sample();
    chk("lu_if_en", 32'(hz.if_en), 32'd0); chk("lu_bubble", 32'(hz.ex_bubble), 32'd1);
    tick(); sample();
    chk("lu_fwd_b", 32'(hz.fwd_b), 32'd2); chk("lu_resume", 32'(hz.if_en), 32'd1);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), PERF ? 32'd1 : 32'd0);
    tick();

    // Youngest wins, and r0 never matches.
    set_id(1, 0, 0, 0, 0, 7, 1, 0); sample(); tick();
    set_id(1, 0, 0, 0, 0, 8, 1, 0); sample(); tick();
    set_id(1, 0, 0, 0, 0, 7, 1, 0); sample(); tick();
    set_id(1, 7, 1, 7, 1, 0, 1, 0); sample();
    chk("young_a", 32'(hz.fwd_a), 32'd1); chk("young_b", 32'(hz.fwd_b), 32'd1);
    tick();
    set_id(1, 0, 1, 0, 1, 0, 0, 0); sample();
    chk("r0_fwd_a", 32'(hz.fwd_a), 32'd0);
    tick();

    // Redirect overrides a load-use hazard.
    set_id(1, 0, 0, 0, 0, 9, 1, 1); sample(); tick();
    set_id(1, 9, 1, 0, 0, 10, 1, 0); hz.redirect = 1'b1; sample();
    chk("rd_flush", 32'(hz.id_flush), 32'd1); chk("rd_if_en", 32'(hz.if_en), 32'd1);
    tick();
    hz.redirect = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("rd_s1_invalid", 32'(hz.stage_valid[0]), 32'd0);
    tick();

    // Freeze with a full pipe.
    set_id(1, 0, 0, 0, 0, 11, 1, 0);
    for (int i = 0; i < 3; i++) begin sample(); tick(); end
    hz.ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("frz_valid", 32'(hz.stage_valid), 32'h7);
      tick();
    end
    hz.ext_stall = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); sample(); tick();
    sample();
    chk("frz_resume", 32'(hz.stage_valid), 32'h6);
    tick();

    // Reset in the middle of a load-use stall.
    set_id(1, 0, 0, 0, 0, 5, 1, 1); sample(); tick();
    set_id(1, 0, 0, 5, 1, 6, 1, 0); reset = 1'b1; sample();
    chk("rst_if_en", 32'(hz.if_en), 32'd1); chk("rst_fwd_b", 32'(hz.fwd_b), 32'd0);
    tick();
    reset = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("rst_valid", 32'(hz.stage_valid), 32'd0);
    tick();

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1),
             $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 4),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      hz.redirect  = ($urandom_range(0, 9) == 0);
      hz.ext_stall = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 49) == 0);
      sample(); tick();
    end
    reset = 1'b0; hz.redirect = 1'b0; hz.ext_stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
